hicore_nop_unit: RTL and testbench
==================================

# hicore_nop_unit

Parametrised NOP/system-op execute unit in the HiCore backend, sitting between the issue stage and the writeback/ROB arbiter. Accepted ops are buffered in a small in-order queue and retired through a valid/ready writeback port, so back-pressure from the arbiter no longer drops results. `fence.i` ops stall at the queue head until an instruction-cache invalidate handshake completes. `mret` ops are tagged on writeback.

## Interface
Parameters:
- `PTR_W`, 4: ROB pointer width.
- `WB_W`, 32: writeback info width.
- `DEPTH`, 2: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `i_issue2nop_valid`  in  1: issue offers an op.
- `i_issue2nop_ready`  out  1: unit can accept.
- `i_issue2nop_cancel`  in  1: offered op is squashed; not enqueued.
- `mret_op`  in  1: offered op is `mret`.
- `fence_i_op`  in  1: offered op is `fence.i`.
- `nop_info`  in  PTR_W+WB_W: {ptr, info}, ptr in MSBs.
- `nop_wb_wen`  out  1: writeback valid.
- `nop_wb_ready`  in  1: arbiter accepts writeback.
- `nop_wb_ptr`  out  PTR_W: ROB pointer of head.
- `nop_wb_info`  out  WB_W: writeback payload of head.
- `nop_wb_mret`  out  1: head is `mret`.
- `fencei_req`  out  1: request I-cache invalidate.
- `fencei_ack`  in  1: invalidate done, one-cycle pulse.
- `flush`  in  1: pipeline flush.

## Operation
- Enqueue when `valid & ready & ~cancel & ~flush`. Each entry stores {ptr, info, mret, fence}.
- `i_issue2nop_ready = ~full`. There is no same-cycle bypass of a pop into a full queue.
- Head writeback:
  - `nop_wb_wen = head_valid & ~flush & (~head_fence | fsm==DONE)`.
  - Pop on `wen & nop_wb_ready`.
  - Data outputs show the head entry whenever the queue is non-empty, and zero when it is empty.
- Fence FSM, states IDLE, REQ, DONE, DRAIN:
  - IDLE→REQ when a fence entry is at the head and there is no flush.
  - REQ holds `fencei_req=1`. REQ→DONE on `fencei_ack`.
  - DONE→IDLE on pop of the fence entry.
  - `fencei_req` is high only in REQ and DRAIN.
- Flush:
  - Queue becomes empty next cycle; pointers and count reset.
  - IDLE or DONE → IDLE.
  - REQ → DRAIN. DRAIN keeps `fencei_req=1` until `fencei_ack`, then → IDLE. The cache operation is never abandoned mid-flight.
  - While in DRAIN, new ops may enqueue. A fence at the head waits for IDLE before entering REQ.
- `fencei_ack` is ignored in IDLE and DONE.
- Ordering is strictly FIFO; entries behind a stalled fence wait.
- Count width is `$clog2(DEPTH)+1`. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.

## Timing
- Reset values: queue empty, FSM IDLE, `i_issue2nop_ready=1`, `nop_wb_wen=0`, `fencei_req=0`, `nop_wb_ptr/info/mret=0`.
- Latency:
  - Non-fence op accepted in cycle N → `wen` in N+1 at earliest.
  - Fence at head in N → `fencei_req` in N+1 → `wen` the cycle after ack.
- Simultaneous push and pop with count < DEPTH: count unchanged, both take effect.
- Flush has priority over push, pop and FSM advance in the same cycle. `wen` is forced low combinationally that cycle.
- `rst` asserted mid-operation, including in REQ or DRAIN, returns everything to reset values immediately. `fencei_req` drops asynchronously.

## Structure
- Shared package `hicore_nop_pkg`:
  - FSM state enum (IDLE/REQ/DONE/DRAIN).
  - Entry struct {ptr, info, mret, fence}.
  - Default widths shared with `config.v` (`HiCore_ROB_PTR_SIZE`, `HiCore_WB_SIZE`).
- One sub-module: `hicore_sync_fifo`, parametrised on width and depth, with push/pop/full/empty/flush.
- The fence FSM and writeback gating stay in the top module.

## Test plan
- DEPTH=2, three back-to-back ops (ptr 1,2,3), `nop_wb_ready=0`:
  - Ready drops after 2 accepts; op 3 is not enqueued.
  - Raise ready: ptr 1 then 2 retire on consecutive cycles.
- Op with `cancel=1`, ptr 5: no enqueue, `wen` never asserts.
- Fence at ptr 4, then nop at ptr 6:
  - `fencei_req` high the cycle after enqueue; ack after 5 cycles.
  - ptr 4 writes back the next cycle, then ptr 6. Neither writes back before ack.
- `mret` at ptr 7: `nop_wb_mret=1` with ptr 7 on the writeback cycle.
- Flush while in REQ with 2 entries:
  - Queue empties and `wen` stays 0.
  - `fencei_req` stays 1 until ack, then drops. A subsequent op writes back normally.
- `rst` pulsed mid-REQ: `fencei_req` and `wen` go to 0 at once; ready=1 after release.

Source files
------------

// File: rtl/hicore_nop_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : hicore_nop_pkg
// Brief  : Shared types and default widths for the HiCore NOP/system-op unit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package hicore_nop_pkg;

  // Mirrors HiCore_ROB_PTR_SIZE / HiCore_WB_SIZE from config.v
  localparam int c_ROB_PTR_SIZE = 4;
  localparam int c_WB_SIZE      = 32;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_REQ   = 2'd1,
    FS_DONE  = 2'd2,
    FS_DRAIN = 2'd3
  } fence_state_t;

  typedef struct packed {
    logic mret;
    logic fence;
  } nop_flags_t;

  localparam int c_FLAGS_W = $bits(nop_flags_t);

  typedef struct packed {
    logic [c_ROB_PTR_SIZE-1:0] ptr;
    logic [c_WB_SIZE-1:0]      info;
    nop_flags_t                flags;
  } nop_entry_t;

endpackage
`default_nettype wire

// File: rtl/hicore_sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : hicore_sync_fifo
// Brief  : Single-clock FIFO with synchronous flush; DEPTH must be a power of 2.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module hicore_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == c_CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/hicore_nop_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : hicore_nop_unit
// Brief  : NOP/system-op execute unit: in-order queue, fence.i invalidate FSM.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module hicore_nop_unit
  import hicore_nop_pkg::*;
#(
  parameter int PTR_W = c_ROB_PTR_SIZE,
  parameter int WB_W  = c_WB_SIZE,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_issue2nop_valid,
  output logic                  i_issue2nop_ready,
  input  logic                  i_issue2nop_cancel,
  input  logic                  mret_op,
  input  logic                  fence_i_op,
  input  logic [PTR_W+WB_W-1:0] nop_info,
  output logic                  nop_wb_wen,
  input  logic                  nop_wb_ready,
  output logic [PTR_W-1:0]      nop_wb_ptr,
  output logic [WB_W-1:0]       nop_wb_info,
  output logic                  nop_wb_mret,
  output logic                  fencei_req,
  input  logic                  fencei_ack,
  input  logic                  flush
);

  localparam int c_ENTRY_W = PTR_W + WB_W + c_FLAGS_W;

  fence_state_t           r_state;
  fence_state_t           w_state_nxt;
  logic [c_ENTRY_W-1:0]   w_wdata;
  logic [c_ENTRY_W-1:0]   w_rdata;
  nop_flags_t             w_head_flags;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_head_fence;

  assign w_wdata      = {nop_info, mret_op, fence_i_op};
  assign w_head_flags = nop_flags_t'(w_rdata[c_FLAGS_W-1:0]);
  assign w_head_fence = ~w_empty & w_head_flags.fence;

  assign i_issue2nop_ready = ~w_full;
  assign w_push = i_issue2nop_valid & ~w_full & ~i_issue2nop_cancel & ~flush;
  assign nop_wb_wen = ~w_empty & ~flush & (~w_head_flags.fence | (r_state == FS_DONE));
  assign w_pop = nop_wb_wen & nop_wb_ready;

  assign nop_wb_ptr  = w_empty ? '0   : w_rdata[c_ENTRY_W-1 -: PTR_W];
  assign nop_wb_info = w_empty ? '0   : w_rdata[c_FLAGS_W +: WB_W];
  assign nop_wb_mret = w_empty ? 1'b0 : w_head_flags.mret;
  assign fencei_req  = (r_state == FS_REQ) | (r_state == FS_DRAIN);

  hicore_sync_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FS_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE:  if (w_head_fence && !flush) w_state_nxt = FS_REQ;
      // A flush coinciding with the ack means the invalidate already finished.
      FS_REQ: begin
        if (flush)           w_state_nxt = fencei_ack ? FS_IDLE : FS_DRAIN;
        else if (fencei_ack) w_state_nxt = FS_DONE;
      end
      FS_DONE:  if (flush || w_pop) w_state_nxt = FS_IDLE;
      FS_DRAIN: if (fencei_ack)     w_state_nxt = FS_IDLE;
      default:  w_state_nxt = FS_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_hicore_nop_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_hicore_nop_unit
// Brief  : Directed and random checks of hicore_nop_unit against a queue model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_hicore_nop_unit;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [3:0]  ptr;
    logic [31:0] info;
    logic        mret;
    logic        fence;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, cancel = 1'b0, mret = 1'b0, fence = 1'b0;
  logic [35:0] nop_info = '0;
  logic        wb_ready = 1'b0, ack = 1'b0, flush = 1'b0;
  logic        ready, wen, wb_mret, req;
  logic [3:0]  wb_ptr;
  logic [31:0] wb_info;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of pending ops plus invalidate bookkeeping.
  ent_t m_q[$];
  bit   m_busy;   // invalidate request outstanding
  bit   m_done;   // head fence has completed its invalidate
  bit   m_drain;  // outstanding request belongs to a flushed fence

  logic       obs_ready, obs_wen, obs_req, obs_mret;
  logic [3:0] obs_ptr;

  always #5 clk = ~clk;

  hicore_nop_unit #(.PTR_W(4), .WB_W(32), .DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_issue2nop_valid  (valid),
    .i_issue2nop_ready  (ready),
    .i_issue2nop_cancel (cancel),
    .mret_op            (mret),
    .fence_i_op         (fence),
    .nop_info           (nop_info),
    .nop_wb_wen         (wen),
    .nop_wb_ready       (wb_ready),
    .nop_wb_ptr         (wb_ptr),
    .nop_wb_info        (wb_info),
    .nop_wb_mret        (wb_mret),
    .fencei_req         (req),
    .fencei_ack         (ack),
    .flush              (flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_done = 0; m_drain = 0;
  endtask

  task automatic drive(input bit v, input bit c, input bit m, input bit f,
                       input logic [3:0] p, input logic [31:0] inf);
    valid = v; cancel = c; mret = m; fence = f; nop_info = {p, inf};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 4'd0, 32'd0);
  endtask

  // One clock: compare outputs with the model, then advance model and DUT.
  task automatic tick();
    ent_t h;
    ent_t n;
    bit   hv, hf, e_wen, push, pop, start;
    #1;
    hv    = m_q.size() > 0;
    h     = hv ? m_q[0] : '0;
    hf    = hv && h.fence;
    e_wen = hv && !flush && (!hf || m_done);
    check("ready",      ready,   (m_q.size() < DEPTH));
    check("wen",        wen,     e_wen);
    check("fencei_req", req,     m_busy);
    check("wb_ptr",     wb_ptr,  h.ptr);
    check("wb_info",    wb_info, h.info);
    check("wb_mret",    wb_mret, h.mret);
    obs_ready = ready; obs_wen = wen; obs_req = req; obs_ptr = wb_ptr; obs_mret = wb_mret;
    push = valid && (m_q.size() < DEPTH) && !cancel && !flush;
    pop  = e_wen && wb_ready;
    n    = '{ptr: nop_info[35:32], info: nop_info[31:0], mret: mret, fence: fence};
    @(posedge clk);
    if (flush) begin
      m_q.delete();
      m_done = 0;
      if (m_busy) begin
        if (ack) begin m_busy = 0; m_drain = 0; end
        else m_drain = 1;
      end
    end else begin
      start = !m_busy && !m_done && hf;
      if (pop) begin void'(m_q.pop_front()); m_done = 0; end
      if (m_busy && ack) begin
        m_busy = 0; m_done = !m_drain; m_drain = 0;
      end else if (start) m_busy = 1;
      if (push) m_q.push_back(n);
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_wen",   wen,   0);
    check("rst_req",   req,   0);
    check("rst_data",  {wb_ptr, wb_info, wb_mret}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-pressure: three ops into a 2-entry queue
    wb_ready = 1'b0;
    drive(1, 0, 0, 0, 4'd1, 32'h1111); tick();
    drive(1, 0, 0, 0, 4'd2, 32'h2222); tick();
    drive(1, 0, 0, 0, 4'd3, 32'h3333); tick();
    check("full_ready_low", obs_ready, 0);
    idle(); wb_ready = 1'b1;
    tick(); check("retire_first",  {obs_wen, obs_ptr}, {1'b1, 4'd1});
    tick(); check("retire_second", {obs_wen, obs_ptr}, {1'b1, 4'd2});
    tick(); check("op3_dropped",   obs_wen, 0);

    // Cancelled op never writes back
    drive(1, 1, 0, 0, 4'd5, 32'h5555); tick();
    idle();
    repeat (3) begin tick(); check("cancel_no_wen", obs_wen, 0); end

    // Fence followed by a plain op
    drive(1, 0, 0, 1, 4'd4, 32'h4444); tick();
    drive(1, 0, 0, 0, 4'd6, 32'h6666); tick();
    idle();
    tick(); check("fence_req_up", obs_req, 1); check("fence_stall", obs_wen, 0);
    repeat (4) begin tick(); check("fence_hold", {obs_req, obs_wen}, 2'b10); end
    ack = 1'b1; tick(); check("fence_ack_cycle", obs_wen, 0);
    ack = 1'b0;
    tick(); check("fence_wb",        {obs_wen, obs_req, obs_ptr}, {2'b10, 4'd4});
    tick(); check("nop_after_fence", {obs_wen, obs_ptr}, {1'b1, 4'd6});

    // mret tag on writeback
    drive(1, 0, 1, 0, 4'd7, 32'h7777); tick();
    idle();
    tick(); check("mret_wb", {obs_wen, obs_mret, obs_ptr}, {2'b11, 4'd7});

    // Flush during REQ with two entries queued
    drive(1, 0, 0, 1, 4'd8, 32'h8888); tick();
    drive(1, 0, 0, 0, 4'd9, 32'h9999); tick();
    idle();
    tick(); check("flush_pre_full", {obs_req, obs_ready}, 2'b10);
    flush = 1'b1; tick(); check("flush_wen_low", obs_wen, 0);
    flush = 1'b0;
    repeat (3) begin tick(); check("drain_hold", {obs_req, obs_wen, obs_ready}, 3'b101); end
    ack = 1'b1; tick();
    ack = 1'b0; tick(); check("drain_done", {obs_req, obs_wen}, 2'b00);
    drive(1, 0, 0, 0, 4'd10, 32'haaaa); tick();
    idle();
    tick(); check("post_flush_wb", {obs_wen, obs_ptr}, {1'b1, 4'd10});

    // Asynchronous reset while REQ is outstanding
    drive(1, 0, 0, 1, 4'd11, 32'hbbbb); tick();
    idle(); tick();
    tick(); check("pre_rst_req", obs_req, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", req, 0);
    check("async_rst_wen", wen, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick(); check("post_rst_ready", obs_ready, 1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      valid    = ($urandom_range(1) == 0);
      cancel   = ($urandom_range(7) == 0);
      mret     = ($urandom_range(3) == 0);
      fence    = ($urandom_range(5) == 0);
      nop_info = {4'($urandom_range(15)), 32'($urandom)};
      flush    = ($urandom_range(19) == 0);
      wb_ready = ($urandom_range(9) < 7);
      ack      = ($urandom_range(4) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
